// File: rtl/exp1_7_sched.sv
// Four-step phase scheduler: on start, walks step index 0..3 for a latched
// number of loops with per-step durations, driving action strobes and counters.
module exp1_7_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] dur_a,
   input  logic [CNT_W-1:0] dur_b,
   input  logic [CNT_W-1:0] loops,
   output logic             busy,
   output logic             done,
   output logic [1:0]       i,
   output logic [CNT_W-1:0] c1,
   output logic [CNT_W-1:0] x,
   output logic [CNT_W-1:0] y,
   output logic             act1,
   output logic             act2
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       i_q, i_d;
   logic [CNT_W-1:0] c1_q, c1_d;
   logic [CNT_W-1:0] x_q, x_d;
   logic [CNT_W-1:0] y_q, y_d;
   logic [CNT_W-1:0] lat_a_q, lat_a_d;
   logic [CNT_W-1:0] lat_b_q, lat_b_d;
   logic [CNT_W-1:0] lat_loops_q, lat_loops_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             act1_q, act1_d;
   logic             act2_q, act2_d;
   logic [CNT_W-1:0] dur_cur;
   logic [CNT_W-1:0] x_inc;

   // Next-state, counters and registered-output precompute
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      c1_d        = c1_q;
      x_d         = x_q;
      y_d         = y_q;
      lat_a_d     = lat_a_q;
      lat_b_d     = lat_b_q;
      lat_loops_d = lat_loops_q;
      dur_cur     = i_q[0] ? lat_b_q : lat_a_q;
      x_inc       = x_q + CNT_ONE;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               lat_a_d     = (dur_a == '0) ? CNT_ONE : dur_a;
               lat_b_d     = (dur_b == '0) ? CNT_ONE : dur_b;
               lat_loops_d = loops;
               x_d         = '0;
               y_d         = '0;
               i_d         = 2'd0;
               c1_d        = '0;
               state_d     = (loops == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (y_q != CNT_MAX) begin
               y_d = y_q + CNT_ONE;
            end
            if (c1_q != dur_cur - CNT_ONE) begin
               c1_d = c1_q + CNT_ONE;
            end else begin
               c1_d = '0;
               i_d  = 2'(i_q + 2'd1);
               if (i_q == 2'd3) begin
                  x_d = x_inc;
                  if (x_inc == lat_loops_q) begin
                     state_d = ST_DONE;
                     i_d     = 2'd0;
                  end
               end
            end
            // Abort overrides any terminal count in the same cycle
            if (abort) begin
               state_d = ST_IDLE;
               i_d     = 2'd0;
               c1_d    = '0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
      act1_d = (state_d == ST_RUN) && (i_d == 2'd0);
      act2_d = (state_d == ST_RUN) && (i_d == 2'd2);
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         i_q         <= 2'd0;
         c1_q        <= '0;
         x_q         <= '0;
         y_q         <= '0;
         lat_a_q     <= '0;
         lat_b_q     <= '0;
         lat_loops_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         act1_q      <= 1'b0;
         act2_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         c1_q        <= c1_d;
         x_q         <= x_d;
         y_q         <= y_d;
         lat_a_q     <= lat_a_d;
         lat_b_q     <= lat_b_d;
         lat_loops_q <= lat_loops_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         act1_q      <= act1_d;
         act2_q      <= act2_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign i    = i_q;
   assign c1   = c1_q;
   assign x    = x_q;
   assign y    = y_q;
   assign act1 = act1_q;
   assign act2 = act2_q;

endmodule

// File: tb/tb_exp1_7_sched.sv
// Directed self-checking bench for exp1_7_sched; outputs sampled on the falling
// edge, k counts cycles after the start-sampling cycle T.
module tb_exp1_7_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [7:0] dur_a, dur_b, loops;
   logic       busy, done, act1, act2;
   logic [1:0] i;
   logic [7:0] c1, x, y;

   int errors = 0;
   int checks = 0;

   exp1_7_sched #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dur_a(dur_a), .dur_b(dur_b), .loops(loops),
      .busy(busy), .done(done), .i(i), .c1(c1), .x(x), .y(y),
      .act1(act1), .act2(act2)
   );

   always #5 clk = ~clk;

   // Drives start for one cycle; returns at the falling edge of cycle T+1
   task automatic start_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] l);
      @(negedge clk);
      dur_a = a;
      dur_b = b;
      loops = l;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      dur_a = 8'd0;
      dur_b = 8'd0;
      loops = 8'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, i, c1, x, y, act1, act2} !== 30'd0) begin
         errors++;
         $display("FAIL reset_outputs got=%h exp=0", {busy, done, i, c1, x, y, act1, act2});
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, done, i, c1, x, y, act1, act2} !== 30'd0) begin
         errors++;
         $display("FAIL reset_idle got=%h exp=0", {busy, done, i, c1, x, y, act1, act2});
      end
   endtask

   // dur_a=2, dur_b=3, loops=2: run cycles k=1..20, done at k=21
   task automatic test_basic(input string tag);
      int p;
      logic [1:0] e_i;
      logic [7:0] e_c1, e_y;
      logic [3:0] e_ctl;
      start_run(8'd2, 8'd3, 8'd2);
      for (int k = 1; k <= 22; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 5) begin
            dur_a = 8'd7;
            dur_b = 8'd0;
            loops = 8'd1;
         end
         p = (k - 1) % 10;
         if (k > 20) begin
            e_i = 2'd0; e_c1 = 8'd0;
         end else if (p < 2) begin
            e_i = 2'd0; e_c1 = 8'(p);
         end else if (p < 5) begin
            e_i = 2'd1; e_c1 = 8'(p - 2);
         end else if (p < 7) begin
            e_i = 2'd2; e_c1 = 8'(p - 5);
         end else begin
            e_i = 2'd3; e_c1 = 8'(p - 7);
         end
         e_y = (k <= 21) ? 8'(k - 1) : 8'd20;
         e_ctl = {k <= 20, k == 21,
                  k == 1 || k == 2 || k == 11 || k == 12,
                  k == 6 || k == 7 || k == 16 || k == 17};
         checks++;
         if ({busy, done, act1, act2} !== e_ctl || i !== e_i || c1 !== e_c1 || y !== e_y) begin
            errors++;
            $display("FAIL %s_cycle k=%0d got busy/done/act1/act2=%b i=%0d c1=%0d y=%0d exp %b i=%0d c1=%0d y=%0d",
                     tag, k, {busy, done, act1, act2}, i, c1, y, e_ctl, e_i, e_c1, e_y);
         end
         if (k == 21) begin
            checks++;
            if (x !== 8'd2) begin
               errors++;
               $display("FAIL %s_final_x got=%0d exp=2", tag, x);
            end
         end
      end
   endtask

   task automatic test_zero_dur();
      start_run(8'd0, 8'd0, 8'd1);
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 4) begin
            checks++;
            if (i !== 2'(k - 1) || busy !== 1'b1 || c1 !== 8'd0 || done !== 1'b0) begin
               errors++;
               $display("FAIL zero_dur_step k=%0d got i=%0d busy=%b c1=%0d done=%b exp i=%0d busy=1 c1=0 done=0",
                        k, i, busy, c1, done, k - 1);
            end
         end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || y !== 8'd4 || x !== 8'd1) begin
               errors++;
               $display("FAIL zero_dur_done got done=%b busy=%b y=%0d x=%0d exp done=1 busy=0 y=4 x=1",
                        done, busy, y, x);
            end
         end
      end
   endtask

   task automatic test_loops_zero();
      start_run(8'd3, 8'd3, 8'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || x !== 8'd0 || y !== 8'd0) begin
         errors++;
         $display("FAIL loops0_done got done=%b busy=%b x=%0d y=%0d exp done=1 busy=0 x=0 y=0",
                  done, busy, x, y);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL loops0_after got done=%b busy=%b exp done=0 busy=0", done, busy);
      end
   endtask

   // 2 * (2*255 + 2*255) = 2040 run cycles
   task automatic test_saturation();
      int early_done = 0;
      start_run(8'd255, 8'd255, 8'd2);
      for (int k = 1; k <= 2042; k++) begin
         if (k > 1) @(negedge clk);
         if (k <= 2040 && done === 1'b1) early_done++;
         if (k == 255 || k == 256 || k == 2040) begin
            checks++;
            if (y !== ((k == 255) ? 8'd254 : 8'd255) || busy !== 1'b1) begin
               errors++;
               $display("FAIL sat_y k=%0d got y=%0d busy=%b exp y=%0d busy=1",
                        k, y, busy, (k == 255) ? 254 : 255);
            end
         end
         if (k == 2041) begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || x !== 8'd2 || y !== 8'd255) begin
               errors++;
               $display("FAIL sat_done got done=%b busy=%b x=%0d y=%0d exp done=1 busy=0 x=2 y=255",
                        done, busy, x, y);
            end
         end
      end
      checks++;
      if (early_done !== 0) begin
         errors++;
         $display("FAIL sat_early_done got=%0d exp=0", early_done);
      end
   endtask

   task automatic test_abort();
      int done_seen = 0;
      start_run(8'd4, 8'd4, 8'd3);
      for (int k = 1; k <= 14; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 3) start = 1'b1;
         if (k == 4) start = 1'b0;
         if (k == 10) abort = 1'b1;
         if (k == 11) abort = 1'b0;
         if (done === 1'b1) done_seen++;
         if (k == 5) begin
            checks++;
            if (i !== 2'd1 || c1 !== 8'd0 || y !== 8'd4 || busy !== 1'b1) begin
               errors++;
               $display("FAIL abort_start_ignored got i=%0d c1=%0d y=%0d busy=%b exp i=1 c1=0 y=4 busy=1",
                        i, c1, y, busy);
            end
         end
         if (k == 11 || k == 14) begin
            checks++;
            if ({busy, done, act1, act2} !== 4'b0000 || i !== 2'd0 || c1 !== 8'd0 ||
                x !== 8'd0 || y !== 8'd10) begin
               errors++;
               $display("FAIL abort_idle k=%0d got ctl=%b i=%0d c1=%0d x=%0d y=%0d exp ctl=0000 i=0 c1=0 x=0 y=10",
                        k, {busy, done, act1, act2}, i, c1, x, y);
            end
         end
      end
      checks++;
      if (done_seen !== 0) begin
         errors++;
         $display("FAIL abort_no_done got=%0d exp=0", done_seen);
      end
      // Abort in the final run cycle beats the terminal count
      start_run(8'd1, 8'd1, 8'd1);
      for (int k = 1; k <= 6; k++) begin
         if (k > 1) @(negedge clk);
         if (k == 4) abort = 1'b1;
         if (k == 5) abort = 1'b0;
         if (k >= 5) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
               errors++;
               $display("FAIL abort_wins k=%0d got done=%b busy=%b exp done=0 busy=0", k, done, busy);
            end
         end
      end
      // Abort while idle must not disturb held counters
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || y !== 8'd4) begin
         errors++;
         $display("FAIL abort_idle_noeffect got busy=%b done=%b y=%0d exp busy=0 done=0 y=4", busy, done, y);
      end
   endtask

   task automatic test_reset_midrun();
      start_run(8'd2, 8'd3, 8'd2);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, i, c1, x, y, act1, act2} !== 30'd0) begin
         errors++;
         $display("FAIL reset_async got=%h exp=0", {busy, done, i, c1, x, y, act1, act2});
      end
      @(negedge clk);
      rst_n = 1'b1;
      test_basic("post_reset");
   endtask

   initial begin
      test_reset();
      test_basic("basic");
      test_zero_dur();
      test_loops_zero();
      test_saturation();
      test_abort();
      test_reset_midrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
